sdatamem_hs: RTL and testbench

Parametrised, handshaked data memory for the core's load/store path. It accepts one request at a time on a valid/ready interface, inserts a configurable number of wait states, and performs the byte, halfword, word or doubleword access in little-endian order. The read result is sign- or zero-extended, and misaligned, out-of-range or illegal-size accesses are reported as errors. It sits between the LSU and the backing byte store.

---
 rtl/sdatamem_hs.sv | 151 +++++++++++++++
 tb/tb_sdatamem_hs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdatamem_hs.sv
// rtl/sdatamem_hs.sv - handshaked little-endian data memory with wait states and fault reporting
module sdatamem_hs #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, uns_q;
    logic [1:0]            size_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [7:0]            mem [DEPTH_BYTES];

    logic                  access;
    logic [3:0]            nbytes;
    logic [32:0]           end_addr;
    logic                  acc_err;
    logic [AW-1:0]         base;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] raw, keep, ext, rdata_next;
    logic                  sign;

    assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
    assign nbytes   = 4'd1 << size_q;
    assign base     = addr_q[AW-1:0];
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr = {1'b0, addr_q} + {29'd0, nbytes};
    assign acc_err  = ((size_q == 2'b11) && (DATA_WIDTH == 32))
                   || (|(addr_q[2:0] & 3'(nbytes - 4'd1)))
                   || (end_addr > 33'(DEPTH_BYTES));

    always_comb begin
        be   = '0;
        raw  = '0;
        keep = '0;
        for (int k = 0; k < NB; k++) begin
            be[k] = (4'(k) < nbytes);
            if (be[k]) begin
                raw[8*k +: 8]  = mem[base + AW'(k)];
                keep[8*k +: 8] = 8'hFF;
            end
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   sign = raw[7];
            2'b01:   sign = raw[15];
            2'b10:   sign = raw[31];
            default: sign = raw[DATA_WIDTH-1];
        endcase
        ext        = raw | ({DATA_WIDTH{sign & ~uns_q}} & ~keep);
        rdata_next = (acc_err || we_q) ? '0 : ext;
    end

    // Byte store has no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (access && we_q && !acc_err) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) begin
                    mem[base + AW'(k)] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        size_q  <= req_size_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= rdata_next;
                        err_q   <= acc_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdatamem_hs.sv
// tb/tb_sdatamem_hs.sv - randomized and directed check of sdatamem_hs against a byte-map model
module tb_sdatamem_hs;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_we, req_uns, resp_ready;
    logic [1:0]  req_ready, resp_valid, resp_err;
    logic [1:0]  req_size [2];
    logic [31:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic [31:0] rdata0;
    logic [63:0] rdata1;

    int checks = 0;
    int fails  = 0;

    bit [7:0] mm [longint];

    always #5 clk = ~clk;

    sdatamem_hs #(.DATA_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_size_i(req_size[0]), .req_unsigned_i(req_uns[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0][31:0]), .resp_valid_o(resp_valid[0]),
        .resp_ready_i(resp_ready[0]), .resp_rdata_o(rdata0), .resp_err_o(resp_err[0])
    );

    sdatamem_hs #(.DATA_WIDTH(64), .DEPTH_BYTES(DEPTH), .WAIT_STATES(3)) u64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_size_i(req_size[1]), .req_unsigned_i(req_uns[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .resp_valid_o(resp_valid[1]),
        .resp_ready_i(resp_ready[1]), .resp_rdata_o(rdata1), .resp_err_o(resp_err[1])
    );

    function automatic int dw_of(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [63:0] act_rd(input int d);
        return (d == 0) ? {32'h0, rdata0} : rdata1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Reference: memory as a sparse byte map, result from size/sign rules
    function automatic void model(input int d, input bit we, input int size, input bit uns,
                                  input logic [31:0] addr, input logic [63:0] wd,
                                  output bit err, output logic [63:0] rd, output bit known);
        int     nb = 1 << size;
        longint key;
        err = (size == 3 && dw_of(d) == 32) || ((addr % nb) != 0)
           || (longint'(addr) + nb > DEPTH);
        rd = '0;
        known = 1'b1;
        if (!err) begin
            for (int k = 0; k < nb; k++) begin
                key = (longint'(d) << 32) + longint'(addr) + k;
                if (we) mm[key] = wd[8*k +: 8];
                else if (!mm.exists(key)) known = 1'b0;
                else rd[8*k +: 8] = mm[key];
            end
            if (we) rd = '0;
            else begin
                if (!uns && nb < 8 && rd[8*nb-1])
                    for (int b = 8 * nb; b < 64; b++) rd[b] = 1'b1;
                if (dw_of(d) == 32) rd[63:32] = '0;
            end
        end
    endfunction

    // Called on a negedge; returns on the negedge right after the response handshake
    task automatic xact(input int d, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wd, input int hold,
                        output logic [63:0] got, output bit gerr);
        bit          e_err, known;
        logic [63:0] e_rd;
        int          k;
        chk("ready_in_idle", {63'd0, req_ready[d]}, 64'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size; req_uns[d] = uns;
        req_addr[d] = addr; req_wdata[d] = wd;
        @(negedge clk);
        model(d, we, int'(size), uns, addr, wd, e_err, e_rd, known);
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = {$urandom, $urandom};
        k = 0;
        while (!resp_valid[d] && k < 40) begin
            chk("ready_low_busy", {63'd0, req_ready[d]}, 64'd0);
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(1 + ws_of(d)));
        got  = act_rd(d);
        gerr = resp_err[d];
        chk("err", {63'd0, gerr}, {63'd0, e_err});
        if (known) chk("rdata", got, e_rd);
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = 1'b1;
            @(negedge clk);
            chk("hold_valid", {63'd0, resp_valid[d]}, 64'd1);
            chk("hold_rdata", act_rd(d), got);
            chk("hold_err", {63'd0, resp_err[d]}, {63'd0, gerr});
            chk("hold_ready", {63'd0, req_ready[d]}, 64'd0);
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk("resp_cleared", {63'd0, resp_valid[d]}, 64'd0);
        chk("ready_back", {63'd0, req_ready[d]}, 64'd1);
    endtask

    task automatic run(input string nm, input int d, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [63:0] wd,
                       input int hold, input logic [63:0] exp_rd, input bit exp_err);
        logic [63:0] got;
        bit          gerr;
        xact(d, we, size, uns, addr, wd, hold, got, gerr);
        chk({nm, "_rd"}, got, exp_rd);
        chk({nm, "_err"}, {63'd0, gerr}, {63'd0, exp_err});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        bit          gerr;
        int          r, step;
        logic [31:0] a;

        req_valid = '0; req_we = '0; req_uns = '0; resp_ready = '0;
        for (int d = 0; d < 2; d++) begin
            req_size[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {63'd0, req_ready[d]}, 64'd1);
            chk("rst_valid", {63'd0, resp_valid[d]}, 64'd0);
            chk("rst_rdata", act_rd(d), 64'd0);
            chk("rst_err", {63'd0, resp_err[d]}, 64'd0);
        end

        // 32-bit, no wait states
        run("sw10",  0, 1, 2'b10, 0, 32'h10, 64'h12345678, 0, 64'h0, 0);
        run("lw10",  0, 0, 2'b10, 0, 32'h10, 64'h0, 0, 64'h12345678, 0);
        run("lbu13", 0, 0, 2'b00, 1, 32'h13, 64'h0, 0, 64'h12, 0);
        run("sb20",  0, 1, 2'b00, 0, 32'h20, 64'h80, 0, 64'h0, 0);
        run("lb20",  0, 0, 2'b00, 0, 32'h20, 64'h0, 0, 64'hFFFFFF80, 0);
        run("lbu20", 0, 0, 2'b00, 1, 32'h20, 64'h0, 0, 64'h80, 0);
        run("sh22",  0, 1, 2'b01, 0, 32'h22, 64'h8001, 0, 64'h0, 0);
        run("lh22",  0, 0, 2'b01, 0, 32'h22, 64'h0, 1, 64'hFFFF8001, 0);
        run("lw11",  0, 0, 2'b10, 0, 32'h11, 64'h0, 0, 64'h0, 1);
        run("swtop", 0, 1, 2'b10, 0, DEPTH - 4, 64'hA5A5A5A5, 0, 64'h0, 0);
        run("swovr", 0, 1, 2'b10, 0, DEPTH - 2, 64'h11223344, 0, 64'h0, 1);
        run("lwtop", 0, 0, 2'b10, 0, DEPTH - 4, 64'h0, 0, 64'hA5A5A5A5, 0);
        run("sz3",   0, 0, 2'b11, 0, 32'h0, 64'h0, 0, 64'h0, 1);
        run("wrap",  0, 0, 2'b10, 0, 32'hFFFFFFFC, 64'h0, 0, 64'h0, 1);

        // 64-bit, three wait states, with backpressure
        run("sd40",  1, 1, 2'b11, 0, 32'h40, 64'h0123456789ABCDEF, 0, 64'h0, 0);
        run("ld40",  1, 0, 2'b11, 0, 32'h40, 64'h0, 4, 64'h0123456789ABCDEF, 0);
        run("lw44",  1, 0, 2'b10, 0, 32'h44, 64'h0, 0, 64'h0000000001234567, 0);
        run("lwu40", 1, 0, 2'b10, 1, 32'h40, 64'h0, 0, 64'h0000000089ABCDEF, 0);
        run("lw40",  1, 0, 2'b10, 0, 32'h40, 64'h0, 0, 64'hFFFFFFFF89ABCDEF, 0);

        // Reset while a store is waiting
        run("sd30",  1, 1, 2'b11, 0, 32'h30, 64'hCAFEF00D5555AAAA, 0, 64'h0, 0);
        run("ld30",  1, 0, 2'b11, 0, 32'h30, 64'h0, 0, 64'hCAFEF00D5555AAAA, 0);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b11; req_uns[1] = 1'b0;
        req_addr[1] = 32'h30; req_wdata[1] = 64'hDEADBEEFDEADBEEF;
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, req_ready[1]}, 64'd1);
        chk("midrst_valid", {63'd0, resp_valid[1]}, 64'd0);
        chk("midrst_rdata", act_rd(1), 64'd0);
        chk("midrst_err", {63'd0, resp_err[1]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", {63'd0, resp_valid[1]}, 64'd0);
        end
        run("ld30b", 1, 0, 2'b11, 0, 32'h30, 64'h0, 0, 64'hCAFEF00D5555AAAA, 0);

        // Fill the random window, then random traffic against the model
        for (int d = 0; d < 2; d++) begin
            step = dw_of(d) / 8;
            for (int i = 0; i < 128; i += step)
                xact(d, 1, (d == 0) ? 2'b10 : 2'b11, 0, 32'(i), {$urandom, $urandom}, 0, got, gerr);
            for (int i = DEPTH - 8; i < DEPTH; i += step)
                xact(d, 1, (d == 0) ? 2'b10 : 2'b11, 0, 32'(i), {$urandom, $urandom}, 0, got, gerr);
            for (int n = 0; n < 120; n++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       a = 32'($urandom_range(0, 127));
                else if (r == 7) a = 32'(DEPTH - 8 + $urandom_range(0, 7));
                else if (r == 8) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                else             a = 32'(DEPTH + $urandom_range(0, 7));
                xact(d, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a,
                     {$urandom, $urandom}, $urandom_range(0, 2), got, gerr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
